// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential shift-add / Booth multiplier.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/mul_seq_step.sv
// One combinational multiply step: conditional add/subtract of M into A,
// then a right shift of {A,Q,Q_1} (logical for unsigned, arithmetic for Booth).
module mul_seq_step
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_q1,
  input  logic [WIDTH-1:0] i_m,
  input  logic             i_mode,
  output logic [WIDTH:0]   o_a,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q1
);

  logic [WIDTH:0] w_m_ext;
  logic [WIDTH:0] w_sum;

  always_comb begin
    w_m_ext = (i_mode == MODE_SIGNED) ? {i_m[WIDTH-1], i_m} : {1'b0, i_m};
    w_sum   = i_a;
    if (i_mode == MODE_SIGNED) begin
      if ({i_q[0], i_q1} == 2'b01)      w_sum = i_a + w_m_ext;
      else if ({i_q[0], i_q1} == 2'b10) w_sum = i_a - w_m_ext;
    end else if (i_q[0]) begin
      w_sum = i_a + w_m_ext;
    end
    // Guard bit absorbs the unsigned carry, so only Booth replicates the sign.
    o_a  = {(i_mode == MODE_SIGNED) & w_sum[WIDTH], w_sum[WIDTH:1]};
    o_q  = {w_sum[0], i_q[WIDTH-1:1]};
    o_q1 = i_q[0];
  end

endmodule

// File: rtl/mul_seq_unit.sv
// Sequential multiplier with start/busy/done handshake, unsigned or Booth mode,
// registered product and flags, and an ALS_mul-gated half-product onto the S-bus.
module mul_seq_unit
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 CLR_N,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  input  logic                 hi_sel,
  input  logic                 ALS_mul,
  output logic [WIDTH-1:0]     ALU_mul_out,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done,
  output logic                 carry,
  output logic                 overflow,
  output logic                 zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e               r_state;
  logic [WIDTH:0]       r_a;
  logic [WIDTH-1:0]     r_q;
  logic                 r_q1;
  logic [WIDTH-1:0]     r_m;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_mode;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_carry;
  logic                 r_ovf;
  logic                 r_zero;
  logic                 r_busy;
  logic                 r_done;

  logic [WIDTH:0]       w_a_nx;
  logic [WIDTH-1:0]     w_q_nx;
  logic                 w_q1_nx;
  logic [2*WIDTH-1:0]   w_prod_nx;
  logic [WIDTH:0]       w_top_bits;
  logic [WIDTH-1:0]     w_half;

  mul_seq_step #(.WIDTH(WIDTH)) u_step (
    .i_a    (r_a),
    .i_q    (r_q),
    .i_q1   (r_q1),
    .i_m    (r_m),
    .i_mode (r_mode),
    .o_a    (w_a_nx),
    .o_q    (w_q_nx),
    .o_q1   (w_q1_nx)
  );

  assign w_prod_nx  = {w_a_nx[WIDTH-1:0], w_q_nx};
  assign w_top_bits = w_prod_nx[2*WIDTH-1:WIDTH-1];

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_q       <= '0;
      r_q1      <= 1'b0;
      r_m       <= '0;
      r_cnt     <= '0;
      r_mode    <= MODE_UNSIGNED;
      r_product <= '0;
      r_carry   <= 1'b0;
      r_ovf     <= 1'b0;
      r_zero    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, FIN: begin
          if (start) begin
            r_m     <= mcand;
            r_q     <= mplier;
            r_a     <= '0;
            r_q1    <= 1'b0;
            r_cnt   <= CNT_W'(WIDTH);
            r_mode  <= signed_mode;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a   <= w_a_nx;
          r_q   <= w_q_nx;
          r_q1  <= w_q1_nx;
          r_cnt <= r_cnt - CNT_W'(1);
          // Last step: capture the product straight from the step outputs.
          if (r_cnt == CNT_W'(1)) begin
            r_product <= w_prod_nx;
            r_carry   <= (r_mode == MODE_UNSIGNED) & (|w_prod_nx[2*WIDTH-1:WIDTH]);
            r_ovf     <= (r_mode == MODE_SIGNED) & ~((&w_top_bits) | ~(|w_top_bits));
            r_zero    <= (w_prod_nx == '0);
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= FIN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_half      = hi_sel ? r_product[2*WIDTH-1:WIDTH] : r_product[WIDTH-1:0];
  assign ALU_mul_out = w_half & {WIDTH{ALS_mul}};

  assign product  = r_product;
  assign busy     = r_busy;
  assign done     = r_done;
  assign carry    = r_carry;
  assign overflow = r_ovf;
  assign zero     = r_zero;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Directed bench for mul_seq_unit (WIDTH=16): vector table plus handshake corner sequences.
module tb_mul_seq_unit;

  logic        CLK;
  logic        CLR_N;
  logic        start;
  logic        signed_mode;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic        hi_sel;
  logic        ALS_mul;
  logic [15:0] ALU_mul_out;
  logic [31:0] product;
  logic        busy;
  logic        done;
  logic        carry;
  logic        overflow;
  logic        zero;

  int checks = 0;
  int errors = 0;

  mul_seq_unit #(.WIDTH(16)) dut (
    .CLK         (CLK),
    .CLR_N       (CLR_N),
    .start       (start),
    .signed_mode (signed_mode),
    .mcand       (mcand),
    .mplier      (mplier),
    .hi_sel      (hi_sel),
    .ALS_mul     (ALS_mul),
    .ALU_mul_out (ALU_mul_out),
    .product     (product),
    .busy        (busy),
    .done        (done),
    .carry       (carry),
    .overflow    (overflow),
    .zero        (zero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        sm;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
    logic        c;
    logic        o;
    logic        z;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge: launch for one cycle, then wait (bounded) for done.
  task automatic launch_wait(input logic sm, input logic [15:0] a, input logic [15:0] b,
                             output int lat, output int bcnt);
    start = 1'b1; signed_mode = sm; mcand = a; mplier = b;
    @(negedge CLK);
    start = 1'b0; mcand = ~a; mplier = ~b; signed_mode = ~sm;
    lat = 1; bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic run_op(input logic sm, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output int bcnt);
    @(negedge CLK);
    launch_wait(sm, a, b, lat, bcnt);
  endtask

  task automatic chk_gate(input string name, input logic [31:0] p);
    ALS_mul = 1'b1; hi_sel = 1'b0; #1;
    chk({name, " alu_lo"}, {16'h0, ALU_mul_out}, {16'h0, p[15:0]});
    hi_sel = 1'b1; #1;
    chk({name, " alu_hi"}, {16'h0, ALU_mul_out}, {16'h0, p[31:16]});
    ALS_mul = 1'b0; #1;
    chk({name, " alu_gated"}, {16'h0, ALU_mul_out}, 32'h0);
    ALS_mul = 1'b1; hi_sel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcnt, ndone, dlat;

    vecs[0]  = '{1'b0, 16'h0003, 16'h0005, 32'h0000000F, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 16'hFFFD, 16'h0007, 32'hFFFFFFEB, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 16'h8000, 16'h8000, 32'h40000000, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 16'h0000, 16'h8000, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 16'h0000, 16'h1234, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 16'h8000, 16'h0001, 32'hFFFF8000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 16'h8000, 16'hFFFF, 32'h00008000, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 16'h8000, 16'h0002, 32'h00010000, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF0001, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 16'h1234, 16'h0001, 32'h00001234, 1'b0, 1'b0, 1'b0};

    CLR_N = 1'b0; start = 1'b0; signed_mode = 1'b0; mcand = '0; mplier = '0;
    hi_sel = 1'b0; ALS_mul = 1'b1;
    repeat (2) @(negedge CLK);
    chk("reset product", product, 32'h0);
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset done", {31'h0, done}, 32'h0);
    chk("reset flags", {29'h0, carry, overflow, zero}, 32'h0);
    chk("reset alu", {16'h0, ALU_mul_out}, 32'h0);
    CLR_N = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].sm, vecs[i].a, vecs[i].b, lat, bcnt);
      chk($sformatf("v%0d latency", i), lat, 17);
      chk($sformatf("v%0d busy_cycles", i), bcnt, 16);
      chk($sformatf("v%0d busy_at_done", i), {31'h0, busy}, 32'h0);
      chk($sformatf("v%0d product", i), product, vecs[i].p);
      chk($sformatf("v%0d flags", i), {29'h0, carry, overflow, zero},
          {29'h0, vecs[i].c, vecs[i].o, vecs[i].z});
      chk_gate($sformatf("v%0d", i), vecs[i].p);
      @(negedge CLK);
      chk($sformatf("v%0d done_pulse", i), {31'h0, done}, 32'h0);
    end

    // Back-to-back: second start issued during the FIN cycle.
    run_op(1'b0, 16'h0003, 16'h0005, lat, bcnt);
    chk("b2b first latency", lat, 17);
    launch_wait(1'b0, 16'h0100, 16'h0100, lat, bcnt);
    chk("b2b second latency", lat, 17);
    chk("b2b second busy_cycles", bcnt, 16);
    chk("b2b second product", product, 32'h00010000);
    chk("b2b second carry", {31'h0, carry}, 32'h1);

    // Start pulsed mid-run must be ignored.
    @(negedge CLK);
    start = 1'b1; signed_mode = 1'b0; mcand = 16'h0003; mplier = 16'h0005;
    @(negedge CLK);
    ndone = 0; dlat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done === 1'b1) begin
        ndone++;
        if (dlat == 0) dlat = c;
      end
      if (c == 3) chk("busy shows previous result", {16'h0, ALU_mul_out}, 32'h0);
      if (c == 5) begin
        start = 1'b1; signed_mode = 1'b1; mcand = 16'h0007; mplier = 16'h0009;
      end else begin
        start = 1'b0;
      end
      @(negedge CLK);
    end
    chk("ignored start latency", dlat, 17);
    chk("ignored start done count", ndone, 1);
    chk("ignored start product", product, 32'h0000000F);

    // Reset in the middle of a run after a result with carry set.
    run_op(1'b0, 16'hFFFF, 16'hFFFF, lat, bcnt);
    chk("pre-reset product", product, 32'hFFFE0001);
    @(negedge CLK);
    start = 1'b1; signed_mode = 1'b0; mcand = 16'h0011; mplier = 16'h0022;
    @(negedge CLK);
    start = 1'b0;
    repeat (7) @(negedge CLK);
    CLR_N = 1'b0; #1;
    chk("midrun reset busy", {31'h0, busy}, 32'h0);
    chk("midrun reset done", {31'h0, done}, 32'h0);
    chk("midrun reset product", product, 32'h0);
    chk("midrun reset flags", {29'h0, carry, overflow, zero}, 32'h0);
    chk("midrun reset alu", {16'h0, ALU_mul_out}, 32'h0);
    @(negedge CLK);
    CLR_N = 1'b1;
    run_op(1'b1, 16'hFFFD, 16'h0007, lat, bcnt);
    chk("post-reset latency", lat, 17);
    chk("post-reset product", product, 32'hFFFFFFEB);
    chk("post-reset flags", {29'h0, carry, overflow, zero}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
